// File: rtl/arashi_thread_sched.sv
// Per-thread fetch scheduler between the thread arbiter and the cache memory.
// Define ARASHI_SCHED_STATS_EN to add the saturating fetch_cnt/stale_cnt outputs.
module arashi_thread_sched #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WIDTH        = 10,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int RD_LATENCY       = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [THREAD_NUM_WIDTH-1:0]       start_tid,
  input  logic [MEM_WIDTH-1:0]              start_pc,
  output logic                              start_err,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]  avail,
  input  logic [THREAD_NUM_WIDTH-1:0]       toread,
  input  logic                              rcache,
  output logic                              ren,
  output logic [MEM_WIDTH-1:0]              raddr,
  output logic [THREAD_NUM_WIDTH-1:0]       rtid,
  input  logic [DATA_WIDTH-1:0]             rdata,
  output logic                              word_valid,
  output logic [THREAD_NUM_WIDTH-1:0]       word_tid,
  output logic [DATA_WIDTH-1:0]             word_data,
  output logic                              done,
  output logic [THREAD_NUM_WIDTH-1:0]       done_tid
`ifdef ARASHI_SCHED_STATS_EN
  ,
  output logic [31:0]                       fetch_cnt,
  output logic [31:0]                       stale_cnt
`endif
);

  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;

  typedef enum logic [1:0] {IDLE, READY, PEND} state_e;

  state_e                      state_q [THREAD_NUM];
  state_e                      state_d [THREAD_NUM];
  logic [MEM_WIDTH-1:0]        pc_q    [THREAD_NUM];
  logic [MEM_WIDTH-1:0]        pc_d    [THREAD_NUM];
  logic                        ren_q, ren_d;
  logic [MEM_WIDTH-1:0]        raddr_q, raddr_d;
  logic [THREAD_NUM_WIDTH-1:0] rtid_q, rtid_d;
  logic [RD_LATENCY-1:0]       pvalid_q, pvalid_d;
  logic [THREAD_NUM_WIDTH-1:0] ptid_q [RD_LATENCY];
  logic [THREAD_NUM_WIDTH-1:0] ptid_d [RD_LATENCY];
  logic                        word_valid_q, word_valid_d;
  logic [THREAD_NUM_WIDTH-1:0] word_tid_q, word_tid_d;
  logic [DATA_WIDTH-1:0]       word_data_q, word_data_d;
  logic                        done_q, done_d;
  logic [THREAD_NUM_WIDTH-1:0] done_tid_q, done_tid_d;
  logic                        start_err_q, start_err_d;

  logic                        grant;
  logic                        ret_valid;
  logic                        ret_halt;
  logic [THREAD_NUM_WIDTH-1:0] ret_tid;

  // A grant for a thread that is not READY is a stale arbiter decision and is dropped.
  assign grant     = rcache && (state_q[toread] == READY);
  assign ret_valid = pvalid_q[RD_LATENCY-1];
  assign ret_tid   = ptid_q[RD_LATENCY-1];
  assign ret_halt  = rdata[DATA_WIDTH-1];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ptid_d       = ptid_q;
    ren_d        = grant;
    raddr_d      = raddr_q;
    rtid_d       = rtid_q;
    start_err_d  = 1'b0;
    word_valid_d = ret_valid;
    word_tid_d   = word_tid_q;
    word_data_d  = word_data_q;
    done_d       = ret_valid && ret_halt;
    done_tid_d   = done_tid_q;

    if (grant) begin
      state_d[toread] = PEND;
      pc_d[toread]    = pc_q[toread] + MEM_WIDTH'(1);
      raddr_d         = pc_q[toread];
      rtid_d          = toread;
    end

    if (start) begin
      if (state_q[start_tid] == IDLE) begin
        state_d[start_tid] = READY;
        pc_d[start_tid]    = start_pc;
      end else begin
        start_err_d = 1'b1;
      end
    end

    // The pipeline tail lines up with rdata, so the returning thread is resolved here.
    if (ret_valid) begin
      state_d[ret_tid] = ret_halt ? IDLE : READY;
      word_tid_d       = ret_tid;
      word_data_d      = rdata;
      if (ret_halt) begin
        done_tid_d = ret_tid;
      end
    end

    pvalid_d[0] = ren_q;
    ptid_d[0]   = rtid_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pvalid_d[i] = pvalid_q[i-1];
      ptid_d[i]   = ptid_q[i-1];
    end

    for (int i = 0; i < THREAD_NUM; i++) begin
      avail[i] = (state_q[i] == READY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < THREAD_NUM; i++) begin
        state_q[i] <= IDLE;
        pc_q[i]    <= '0;
      end
      for (int i = 0; i < RD_LATENCY; i++) begin
        ptid_q[i] <= '0;
      end
      pvalid_q     <= '0;
      ren_q        <= 1'b0;
      raddr_q      <= '0;
      rtid_q       <= '0;
      word_valid_q <= 1'b0;
      word_tid_q   <= '0;
      word_data_q  <= '0;
      done_q       <= 1'b0;
      done_tid_q   <= '0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ptid_q       <= ptid_d;
      pvalid_q     <= pvalid_d;
      ren_q        <= ren_d;
      raddr_q      <= raddr_d;
      rtid_q       <= rtid_d;
      word_valid_q <= word_valid_d;
      word_tid_q   <= word_tid_d;
      word_data_q  <= word_data_d;
      done_q       <= done_d;
      done_tid_q   <= done_tid_d;
      start_err_q  <= start_err_d;
    end
  end

  assign ren        = ren_q;
  assign raddr      = raddr_q;
  assign rtid       = rtid_q;
  assign word_valid = word_valid_q;
  assign word_tid   = word_tid_q;
  assign word_data  = word_data_q;
  assign done       = done_q;
  assign done_tid   = done_tid_q;
  assign start_err  = start_err_q;

`ifdef ARASHI_SCHED_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stale_cnt_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_cnt_q <= '0;
      stale_cnt_q <= '0;
    end else begin
      if (grant && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (rcache && !grant && (stale_cnt_q != '1)) begin
        stale_cnt_q <= stale_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stale_cnt = stale_cnt_q;
`endif

endmodule
